// File: rtl/mac_array_acc_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mac_array_acc_if
// Brief    : Beat, weight and result bundle for the MAC array accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface mac_array_acc_if #(
    parameter int DW     = 8,
    parameter int ROW    = 8,
    parameter int COLUMN = 6,
    parameter int CW     = 19,
    parameter int OW     = 22
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_first;
    logic                    in_last;
    logic [ROW*DW-1:0]       in_data;
    logic [COLUMN*CW-1:0]    ci;
    logic [COLUMN*DW-1:0]    w;
    logic [ROW-1:0]          w_en;
    logic                    relu_en;
    logic                    out_valid;
    logic                    out_ready;
    logic [COLUMN*OW-1:0]    out_data;

    modport master (
        output in_valid, in_first, in_last, in_data, ci, w, w_en, relu_en, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_first, in_last, in_data, ci, w, w_en, relu_en, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/mac_array_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mac_array_acc
// Brief    : Weight-stationary ROW x COLUMN MAC array with skewed inputs, a
//            registered partial-sum chain and a saturating frame accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module mac_array_acc #(
    parameter int DW     = 8,
    parameter int ROW    = 8,
    parameter int COLUMN = 6,
    parameter int CW     = 19,
    parameter int OW     = 22
) (
    input  logic            clk,
    input  logic            rst_n,
    mac_array_acc_if.slave  bus
);

    logic                          adv;
    logic                          out_valid_q;
    logic [COLUMN*OW-1:0]          out_data_q;
    logic [COLUMN*OW-1:0]          out_d;

    logic [ROW*DW-1:0]             x_skew;
    logic [(ROW+1)*COLUMN*CW-1:0]  chain;
    logic [ROW:0]                  chain_v;
    logic [ROW:0]                  chain_f;
    logic [ROW:0]                  chain_l;

    logic                          acc_emit_q;
    logic [COLUMN*OW-1:0]          acc_q;
    logic [COLUMN*OW-1:0]          acc_d;

    // The whole datapath advances only when the result slot can take a new value.
    assign bus.in_ready  = !(out_valid_q && !bus.out_ready);
    assign adv           = bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    assign chain[0 +: COLUMN*CW] = bus.ci;
    assign chain_v[0]            = bus.in_valid;
    assign chain_f[0]            = bus.in_first;
    assign chain_l[0]            = bus.in_last;
    assign x_skew[0 +: DW]       = bus.in_data[0 +: DW];

    for (genvar r = 0; r < ROW; r++) begin : g_row
        logic [COLUMN*DW-1:0] w_row_q;
        logic [COLUMN*CW-1:0] psum_d;
        logic [COLUMN*CW-1:0] psum_q;
        logic                 v_q;
        logic                 f_q;
        logic                 l_q;

        // Weight loads ignore the stall so the loader never waits on the array.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                w_row_q <= '0;
            end else if (bus.w_en[r]) begin
                w_row_q <= bus.w;
            end
        end

        if (r > 0) begin : g_skew
            logic [DW-1:0] skew_q [r];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < r; k++) begin
                        skew_q[k] <= '0;
                    end
                end else if (adv) begin
                    skew_q[0] <= bus.in_data[r*DW +: DW];
                    for (int k = 1; k < r; k++) begin
                        skew_q[k] <= skew_q[k-1];
                    end
                end
            end

            assign x_skew[r*DW +: DW] = skew_q[r-1];
        end

        for (genvar c = 0; c < COLUMN; c++) begin : g_col
            logic signed [2*DW-1:0] xe;
            logic signed [2*DW-1:0] we;
            logic signed [2*DW-1:0] prod;

            assign xe   = (2*DW)'($signed(x_skew[r*DW +: DW]));
            assign we   = (2*DW)'($signed(w_row_q[c*DW +: DW]));
            assign prod = xe * we;
            assign psum_d[c*CW +: CW] = chain[(r*COLUMN + c)*CW +: CW] + CW'(prod);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                psum_q <= '0;
                v_q    <= 1'b0;
                f_q    <= 1'b0;
                l_q    <= 1'b0;
            end else if (adv) begin
                v_q    <= chain_v[r];
                f_q    <= chain_f[r];
                l_q    <= chain_l[r];
                psum_q <= psum_d;
            end
        end

        assign chain[(r+1)*COLUMN*CW +: COLUMN*CW] = psum_q;
        assign chain_v[r+1] = v_q;
        assign chain_f[r+1] = f_q;
        assign chain_l[r+1] = l_q;
    end

    for (genvar c = 0; c < COLUMN; c++) begin : g_acc
        logic signed [CW-1:0] res;
        logic signed [OW:0]   sum;
        logic signed [OW-1:0] sat;

        assign res = chain[(ROW*COLUMN + c)*CW +: CW];
        assign sum = (OW+1)'($signed(acc_q[c*OW +: OW])) + (OW+1)'(res);

        // A carry into the guard bit that disagrees with the sign means overflow.
        always_comb begin
            sat = sum[OW-1:0];
            if (sum[OW] != sum[OW-1]) begin
                sat = sum[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
            end
        end

        assign acc_d[c*OW +: OW] = chain_f[ROW] ? OW'(res) : sat;
        assign out_d[c*OW +: OW] = (bus.relu_en && acc_q[c*OW + OW - 1]) ? '0 : acc_q[c*OW +: OW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            acc_emit_q <= 1'b0;
        end else if (adv) begin
            acc_emit_q <= chain_v[ROW] && chain_l[ROW];
            if (chain_v[ROW]) begin
                acc_q <= acc_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (adv && acc_emit_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_d;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_array_acc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mac_array_acc
// Brief    : Scoreboard bench for mac_array_acc with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_array_acc;
    localparam int DW     = 8;
    localparam int ROW    = 8;
    localparam int COLUMN = 6;
    localparam int CW     = 19;
    localparam int OW     = 22;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_array_acc_if #(.DW(DW), .ROW(ROW), .COLUMN(COLUMN), .CW(CW), .OW(OW)) bus ();

    mac_array_acc #(.DW(DW), .ROW(ROW), .COLUMN(COLUMN), .CW(CW), .OW(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [ROW*DW-1:0]    x;
        logic [COLUMN*CW-1:0] ci;
        logic                 first;
        logic                 last;
        int                   n0;
    } beat_t;

    // Model state: a beat accepted on advancing edge n uses row r weights as
    // they stood at advancing edge n+r, is accumulated at n+ROW, emitted at n+ROW+1.
    beat_t                       inflight[$];
    logic [ROW*COLUMN*DW-1:0]    wsnap[$];
    logic [ROW*COLUMN*DW-1:0]    wmod = '0;
    longint                      macc[COLUMN];
    longint                      pend[COLUMN];
    bit                          pend_v = 1'b0;
    bit                          mvalid = 1'b0;
    int                          nadv = 0;
    logic [COLUMN*OW-1:0]        expq[$];

    bit                          held_v = 1'b0;
    logic [COLUMN*OW-1:0]        held_d = '0;

    task automatic chk(input string name, input logic [COLUMN*OW-1:0] act, input logic [COLUMN*OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int bits);
        longint m;
        m = v & ((longint'(1) << bits) - 1);
        if (m[bits-1]) m = m - (longint'(1) << bits);
        return m;
    endfunction

    function automatic longint sat(input longint v);
        longint hi;
        longint lo;
        hi = (longint'(1) << (OW-1)) - 1;
        lo = -(longint'(1) << (OW-1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic [COLUMN*OW-1:0] rep(input longint v);
        logic [COLUMN*OW-1:0] r;
        for (int c = 0; c < COLUMN; c++) r[c*OW +: OW] = v[OW-1:0];
        return r;
    endfunction

    task automatic model_step();
        bit                       adv;
        bit                       emit;
        beat_t                    b;
        longint                   rv;
        logic [COLUMN*OW-1:0]     ev;
        logic [ROW*COLUMN*DW-1:0] ws;
        if (!rst_n) begin
            inflight.delete(); wsnap.delete(); expq.delete();
            for (int c = 0; c < COLUMN; c++) begin macc[c] = 0; pend[c] = 0; end
            pend_v = 1'b0; mvalid = 1'b0; nadv = 0; wmod = '0;
            return;
        end
        adv = !(mvalid && !bus.out_ready);
        if (adv) begin
            wsnap.push_back(wmod);
            emit = pend_v;
            if (pend_v) begin
                ev = '0;
                for (int c = 0; c < COLUMN; c++) begin
                    rv = pend[c];
                    if (bus.relu_en && rv < 0) rv = 0;
                    ev[c*OW +: OW] = rv[OW-1:0];
                end
                expq.push_back(ev);
                pend_v = 1'b0;
            end
            if (inflight.size() > 0 && inflight[0].n0 + ROW == nadv) begin
                b = inflight.pop_front();
                for (int c = 0; c < COLUMN; c++) begin
                    rv = sx(longint'(b.ci[c*CW +: CW]), CW);
                    for (int r = 0; r < ROW; r++) begin
                        ws = wsnap[b.n0 + r];
                        rv = rv + sx(longint'(b.x[r*DW +: DW]), DW) * sx(longint'(ws[(r*COLUMN + c)*DW +: DW]), DW);
                    end
                    rv = sx(rv, CW);
                    macc[c] = b.first ? rv : sat(macc[c] + rv);
                end
                if (b.last) begin
                    for (int c = 0; c < COLUMN; c++) pend[c] = macc[c];
                    pend_v = 1'b1;
                end
            end
            if (bus.in_valid) begin
                b.x = bus.in_data; b.ci = bus.ci; b.first = bus.in_first;
                b.last = bus.in_last; b.n0 = nadv;
                inflight.push_back(b);
            end
            nadv++;
            mvalid = emit ? 1'b1 : (bus.out_ready ? 1'b0 : mvalid);
        end
        for (int r = 0; r < ROW; r++) begin
            if (bus.w_en[r]) wmod[r*COLUMN*DW +: COLUMN*DW] = bus.w;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                chki("in_ready", int'(bus.in_ready), int'(!(mvalid && !bus.out_ready)));
                chki("out_valid", int'(bus.out_valid), int'(mvalid));
                if (held_v && bus.out_valid) chk("out_hold", bus.out_data, held_d);
                if (bus.out_valid && bus.out_ready) begin
                    if (expq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL result: got unexpected output %h expected none", bus.out_data);
                    end else begin
                        chk("result", bus.out_data, expq.pop_front());
                    end
                end
                held_v = bus.out_valid && !bus.out_ready;
                held_d = bus.out_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [DW-1:0] v);
        bus.w    = {COLUMN{v}};
        bus.w_en = '1;
        step();
        bus.w_en = '0;
    endtask

    task automatic beat(input logic [DW-1:0] x, input logic f, input logic l);
        bus.in_data  = {ROW{x}};
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [COLUMN*OW-1:0] exp);
        int n;
        logic [COLUMN*OW-1:0] got;
        n = 0;
        got = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (n == 0) got = bus.out_data;
                n++;
            end
        end
        chki({name, "_count"}, n, 1);
        chk(name, got, exp);
    endtask

    initial begin
        int seen;
        int guard;
        logic [COLUMN*OW-1:0] got;

        bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.in_data = '0; bus.ci = '0; bus.w = '0; bus.w_en = '0;
        bus.relu_en = 1'b0; bus.out_ready = 1'b1;

        #12;
        chki("reset_out_valid", int'(bus.out_valid), 0);
        chki("reset_in_ready", int'(bus.in_ready), 1);
        chk("reset_out_data", bus.out_data, '0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Single-tile frame and exact latency.
        load_w(8'd1);
        beat(8'd2, 1'b1, 1'b1);
        seen = -1;
        got = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.out_valid && seen < 0) begin
                seen = k;
                got = bus.out_data;
            end
        end
        chki("latency", seen, ROW + 1);
        chk("single_tile", got, rep(16));

        load_w(8'd3);
        beat(8'd1, 1'b1, 1'b0);
        beat(8'd1, 1'b0, 1'b0);
        beat(8'd1, 1'b0, 1'b1);
        wait_result("three_tile", rep(72));

        load_w(8'h80);
        for (int i = 0; i < 16; i++) beat(8'h80, i == 0, i == 15);
        wait_result("saturate", rep(2097151));

        load_w(8'd5);
        beat(8'hFF, 1'b1, 1'b1);
        wait_result("relu_off", rep(-40));
        bus.relu_en = 1'b1;
        beat(8'hFF, 1'b1, 1'b1);
        wait_result("relu_on", rep(0));
        bus.relu_en = 1'b0;

        // Back-to-back frames with a 5-cycle output stall and a row-3 weight rewrite.
        load_w(8'd1);
        for (int i = 0; i < 30; i++) begin
            for (int r = 0; r < ROW; r++) bus.in_data[r*DW +: DW] = DW'($urandom);
            bus.in_valid = 1'b1; bus.in_first = 1'b1; bus.in_last = 1'b1;
            bus.out_ready = !(i >= ROW + 4 && i < ROW + 9);
            bus.w_en = '0;
            if (i == ROW + 6) begin
                bus.w_en[3] = 1'b1;
                for (int c = 0; c < COLUMN; c++) bus.w[c*DW +: DW] = DW'($urandom);
            end
            if (i >= ROW + 4 && i < ROW + 9) begin
                @(negedge clk);
                chki("stall_in_ready", int'(bus.in_ready), 0);
            end
            step();
        end
        bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.w_en = '0; bus.out_ready = 1'b1;
        repeat (20) step();

        // Reset with beats in flight.
        load_w(8'd2);
        beat(8'd1, 1'b1, 1'b0);
        beat(8'd1, 1'b0, 1'b0);
        beat(8'd1, 1'b0, 1'b0);
        beat(8'd1, 1'b0, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chki("midrst_out_valid", int'(bus.out_valid), 0);
        chki("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_out_data", bus.out_data, '0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < COLUMN; c++) bus.ci[c*CW +: CW] = CW'(7);
        beat(8'd5, 1'b1, 1'b1);
        bus.ci = '0;
        wait_result("weights_cleared", rep(7));
        load_w(8'd1);
        beat(8'd3, 1'b1, 1'b1);
        wait_result("post_reset", rep(24));

        // Randomised traffic.
        for (int i = 0; i < 700; i++) begin
            bus.in_valid = ($urandom % 4) != 0;
            bus.in_first = ($urandom % 4) == 0;
            bus.in_last  = ($urandom % 3) == 0;
            for (int r = 0; r < ROW; r++) bus.in_data[r*DW +: DW] = DW'($urandom);
            for (int c = 0; c < COLUMN; c++) bus.ci[c*CW +: CW] = ($urandom % 2 == 0) ? CW'($urandom) : '0;
            for (int c = 0; c < COLUMN; c++) bus.w[c*DW +: DW] = DW'($urandom);
            bus.w_en      = (($urandom % 5) == 0) ? ROW'($urandom) : '0;
            bus.relu_en   = ($urandom % 2) == 0;
            bus.out_ready = ($urandom % 4) != 0;
            step();
        end

        bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.w_en = '0; bus.out_ready = 1'b1;
        guard = 0;
        while ((expq.size() != 0 || mvalid) && guard < 100) begin
            step();
            guard++;
        end
        repeat (3) step();
        chki("drain_done", int'(guard < 100), 1);
        chki("leftover_expected", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
